// File: rtl/probe_request_scheduler_if.sv
// probe_request_scheduler_if: memory read request/response port between scheduler and memory
interface probe_request_scheduler_if;
  logic        req_valid_out;
  logic        req_ready_in;
  logic [63:0] req_addr_out;
  logic        rsp_valid_in;
  modport master (output req_valid_out, req_addr_out, input req_ready_in, rsp_valid_in);
  modport slave  (input req_valid_out, req_addr_out, output req_ready_in, rsp_valid_in);
endinterface

// File: rtl/probe_request_scheduler.sv
// probe_request_scheduler: walks [start, end) by step issuing capped outstanding memory reads
module probe_request_scheduler #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int OUTST_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          go_in,
  input  logic [63:0]                   start_in,
  input  logic [63:0]                   end_in,
  input  logic [63:0]                   step_in,
  probe_request_scheduler_if.master     req,
  output logic                          busy_out,
  output logic                          done_out,
  output logic                          err_out,
  output logic [63:0]                   issued_count_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [OUTST_W-1:0] MAX_O = OUTST_W'(MAX_OUTSTANDING);
  state_t state_q, state_d;
  logic [63:0] addr_q, addr_d, end_q, end_d, step_q, step_d, issued_q, issued_d;
  logic [OUTST_W-1:0] outst_q, outst_d;
  logic err_q, err_d;
  logic go_acc, fire, rsp, exhausted, stray_rsp;
  logic [64:0] next;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      end_q    <= '0;
      step_q   <= '0;
      issued_q <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      end_q    <= end_d;
      step_q   <= step_d;
      issued_q <= issued_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go_in) state_d = (start_in >= end_in || step_in == '0) ? DONE : ISSUE;
      ISSUE:   if (fire && exhausted) state_d = DRAIN;
      DRAIN:   if (outst_q == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // 65-bit sum so a carry out of the address space ends the job instead of wrapping
  always_comb begin
    go_acc    = (state_q == IDLE) && go_in;
    fire      = req.req_valid_out && req.req_ready_in;
    rsp       = req.rsp_valid_in;
    next      = {1'b0, addr_q} + {1'b0, step_q};
    exhausted = next[64] || (next[63:0] >= end_q);
    stray_rsp = rsp && !fire && (outst_q == '0);
    addr_d    = go_acc ? start_in : (fire && !exhausted) ? next[63:0] : addr_q;
    end_d     = go_acc ? end_in : end_q;
    step_d    = go_acc ? step_in : step_q;
    issued_d  = go_acc ? '0 : issued_q + 64'(fire);
    outst_d   = (fire && !rsp) ? outst_q + 1'b1 : (rsp && !fire && outst_q != '0) ? outst_q - 1'b1 : outst_q;
    err_d     = go_acc ? (step_in == '0 && start_in < end_in) : (err_q || stray_rsp);
  end
  always_comb begin
    req.req_valid_out = (state_q == ISSUE) && (outst_q < MAX_O);
    req.req_addr_out  = addr_q;
    busy_out          = state_q != IDLE;
    done_out          = state_q == DONE;
    err_out           = err_q;
    issued_count_out  = issued_q;
  end
endmodule

// File: tb/tb_probe_request_scheduler.sv
// tb_probe_request_scheduler: directed checks of address walk, outstanding cap, drain and errors
module tb_probe_request_scheduler;
  logic clk = 1'b0;
  logic rst, go_in, busy_out, done_out, err_out;
  logic [63:0] start_in, end_in, step_in, issued_count_out;
  int total = 0;
  int bad = 0;
  int fires;
  probe_request_scheduler_if bus ();
  probe_request_scheduler dut (
    .clk(clk), .rst(rst), .go_in(go_in), .start_in(start_in), .end_in(end_in),
    .step_in(step_in), .req(bus), .busy_out(busy_out), .done_out(done_out),
    .err_out(err_out), .issued_count_out(issued_count_out)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic go(input logic [63:0] s, input logic [63:0] e, input logic [63:0] st);
    start_in = s;
    end_in = e;
    step_in = st;
    go_in = 1'b1;
    cyc();
    go_in = 1'b0;
  endtask
  initial begin
    rst = 1'b1; go_in = 1'b0; start_in = '0; end_in = '0; step_in = '0;
    bus.req_ready_in = 1'b0; bus.rsp_valid_in = 1'b0;
    cyc(); cyc();
    chk("rst_valid", bus.req_valid_out, 0);
    chk("rst_busy", busy_out, 0);
    rst = 1'b0;
    cyc();
    chk("idle_addr", bus.req_addr_out, 0);
    chk("idle_done", done_out, 0);
    chk("idle_err", err_out, 0);
    chk("idle_issued", issued_count_out, 0);
    // walk 0x100..0x130, each response two cycles after its fire
    bus.req_ready_in = 1'b1;
    go(64'h100, 64'h140, 64'h10);
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", bus.req_valid_out, 1);
      chk("t1_addr", bus.req_addr_out, 64'h100 + 64'(i) * 64'h10);
      chk("t1_busy", busy_out, 1);
      bus.rsp_valid_in = (i >= 2);
      cyc();
    end
    chk("t1_drain_valid", bus.req_valid_out, 0);
    cyc();
    cyc();
    bus.rsp_valid_in = 1'b0;
    chk("t1_no_early_done", done_out, 0);
    cyc();
    chk("t1_done", done_out, 1);
    chk("t1_issued", issued_count_out, 4);
    chk("t1_err", err_out, 0);
    cyc();
    chk("t1_done_pulse", done_out, 0);
    chk("t1_idle", busy_out, 0);
    // 32 addresses, no responses: cap at 16 in flight
    go(64'h0, 64'h200, 64'h10);
    fires = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_valid_out) fires++;
      cyc();
    end
    chk("t2_fires_cap", 64'(fires), 16);
    chk("t2_valid_off", bus.req_valid_out, 0);
    chk("t2_issued16", issued_count_out, 16);
    bus.rsp_valid_in = 1'b1;
    cyc();
    bus.rsp_valid_in = 1'b0;
    fires = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.req_valid_out) fires++;
      cyc();
    end
    chk("t2_one_more", 64'(fires), 1);
    chk("t2_issued17", issued_count_out, 17);
    // backpressure: valid and address hold while ready is low
    bus.req_ready_in = 1'b0;
    bus.rsp_valid_in = 1'b1;
    cyc();
    bus.rsp_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", bus.req_valid_out, 1);
      chk("t3_hold_addr", bus.req_addr_out, 64'h110);
      cyc();
    end
    chk("t3_still_17", issued_count_out, 17);
    bus.req_ready_in = 1'b1;
    cyc();
    chk("t3_fired", issued_count_out, 18);
    chk("t3_next_addr", bus.req_addr_out, 64'h120);
    // reset mid-ISSUE
    rst = 1'b1;
    cyc();
    chk("t6_rst_busy", busy_out, 0);
    chk("t6_rst_valid", bus.req_valid_out, 0);
    chk("t6_rst_addr", bus.req_addr_out, 0);
    chk("t6_rst_issued", issued_count_out, 0);
    rst = 1'b0;
    cyc();
    // empty job and zero step
    go(64'h40, 64'h40, 64'h8);
    chk("t4_empty_done", done_out, 1);
    chk("t4_empty_valid", bus.req_valid_out, 0);
    chk("t4_empty_err", err_out, 0);
    cyc();
    chk("t4_empty_pulse", done_out, 0);
    chk("t4_empty_issued", issued_count_out, 0);
    go(64'h0, 64'h40, 64'h0);
    chk("t4_step0_done", done_out, 1);
    chk("t4_step0_err", err_out, 1);
    cyc();
    chk("t4_step0_sticky", err_out, 1);
    chk("t4_step0_issued", issued_count_out, 0);
    // carry out of address space ends the walk after one request
    go(64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h20);
    chk("t5_err_cleared", err_out, 0);
    chk("t5_valid", bus.req_valid_out, 1);
    chk("t5_addr", bus.req_addr_out, 64'hFFFF_FFFF_FFFF_FFF0);
    cyc();
    chk("t5_drain", bus.req_valid_out, 0);
    chk("t5_issued", issued_count_out, 1);
    chk("t5_busy", busy_out, 1);
    bus.rsp_valid_in = 1'b1;
    cyc();
    bus.rsp_valid_in = 1'b0;
    cyc();
    chk("t5_done", done_out, 1);
    cyc();
    // stray response while idle
    bus.rsp_valid_in = 1'b1;
    cyc();
    bus.rsp_valid_in = 1'b0;
    chk("t6_stray_err", err_out, 1);
    // fire and response in the same cycle leave the count unchanged
    go(64'h0, 64'h30, 64'h10);
    chk("t6_go_clears_err", err_out, 0);
    cyc();
    bus.rsp_valid_in = 1'b1;
    cyc();
    bus.rsp_valid_in = 1'b0;
    cyc();
    chk("t6_drain", bus.req_valid_out, 0);
    bus.rsp_valid_in = 1'b1;
    cyc();
    bus.rsp_valid_in = 1'b0;
    cyc();
    chk("t6_one_left", done_out, 0);
    bus.rsp_valid_in = 1'b1;
    cyc();
    bus.rsp_valid_in = 1'b0;
    cyc();
    chk("t6_done", done_out, 1);
    chk("t6_issued", issued_count_out, 3);
    chk("t6_err", err_out, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
